// File: rtl/phase_sequencer.sv
// phase_sequencer
//   Generates the 5-phase instruction cycle (1 fetch, 2 decode/read,
//   3 execute, 4 memory, 5 write-back) for the multi-cycle processor.
//   Handles run / single-step from the exec push-button, halt from the
//   decoder, memory-wait stalls, a PC breakpoint and a saturating
//   retired-instruction counter.
//
// Ports
//   clk          system clock, all state on rising edge
//   rst          asynchronous reset, active low
//   exec         raw push-button, active low, asynchronous to clk
//   step_mode    1 = one instruction per press, 0 = free run
//   hlt          halt instruction decoded (sampled in phases 2-5)
//   mem_wait     memory not ready (sampled in phases 1 and 4)
//   bp_en        breakpoint enable
//   bp_addr      breakpoint address
//   pc           program counter (already advanced when phase 5 is reached)
//   phase        0 = idle/halted, 1..5 = active phase
//   executing    1 while phase is 1..5
//   halted       sticky halt flag, cleared by a press
//   brk_hit      one-cycle pulse when the breakpoint stops execution
//   instr_count  retired instructions, saturating, cleared only by reset
module phase_sequencer #(
   parameter int unsigned CNT_W = 16,
   parameter int unsigned PC_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             exec,
   input  logic             step_mode,
   input  logic             hlt,
   input  logic             mem_wait,
   input  logic             bp_en,
   input  logic [PC_W-1:0]  bp_addr,
   input  logic [PC_W-1:0]  pc,
   output logic [2:0]       phase,
   output logic             executing,
   output logic             halted,
   output logic             brk_hit,
   output logic [CNT_W-1:0] instr_count
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [2:0]       phase_nxt;
   logic             brk_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             step_lat, step_nxt;
   logic             stop_req, stop_nxt;
   logic             hlt_seen, hlt_nxt;

   // Button synchronizer plus one delay flop; idle level is 1 (released)
   logic s1, s2, s3;
   logic press;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1 <= 1'b1;
         s2 <= 1'b1;
         s3 <= 1'b1;
      end else begin
         s1 <= exec;
         s2 <= s1;
         s3 <= s2;
      end
   end

   // One-cycle pulse per synchronized falling edge of exec
   assign press = s3 & ~s2;

   always_comb begin
      state_nxt = state;
      phase_nxt = phase;
      brk_nxt   = 1'b0;
      cnt_nxt   = instr_count;
      step_nxt  = step_lat;
      stop_nxt  = stop_req;
      hlt_nxt   = hlt_seen;

      unique case (state)
         ST_IDLE: begin
            if (press) begin
               state_nxt = ST_RUN;
               phase_nxt = 3'd1;
               step_nxt  = step_mode;
            end
         end

         ST_RUN: begin
            if (press)
               stop_nxt = 1'b1;
            if (hlt && (phase >= 3'd2))
               hlt_nxt = 1'b1;

            case (phase)
               3'd1, 3'd4: begin
                  if (!mem_wait)
                     phase_nxt = phase + 3'd1;
               end
               3'd2, 3'd3: begin
                  phase_nxt = phase + 3'd1;
               end
               3'd5: begin
                  // Leaving write-back: retire, clear per-instruction flags,
                  // then pick the destination by priority.
                  stop_nxt = 1'b0;
                  hlt_nxt  = 1'b0;
                  if (instr_count != '1)
                     cnt_nxt = instr_count + CNT_W'(1);

                  if (hlt_seen || hlt) begin
                     state_nxt = ST_HALT;
                     phase_nxt = 3'd0;
                  end else if (bp_en && (pc == bp_addr)) begin
                     state_nxt = ST_IDLE;
                     phase_nxt = 3'd0;
                     brk_nxt   = 1'b1;
                  end else if (step_lat || stop_req || press) begin
                     state_nxt = ST_IDLE;
                     phase_nxt = 3'd0;
                  end else begin
                     phase_nxt = 3'd1;
                  end
               end
               default: begin
                  // Unreachable phase encoding: fall back to idle
                  state_nxt = ST_IDLE;
                  phase_nxt = 3'd0;
                  stop_nxt  = 1'b0;
                  hlt_nxt   = 1'b0;
               end
            endcase
         end

         ST_HALT: begin
            // Press only clears the halt; a further press starts execution
            if (press)
               state_nxt = ST_IDLE;
         end

         default: begin
            state_nxt = ST_IDLE;
            phase_nxt = 3'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_IDLE;
         phase       <= '0;
         executing   <= 1'b0;
         halted      <= 1'b0;
         brk_hit     <= 1'b0;
         instr_count <= '0;
         step_lat    <= 1'b0;
         stop_req    <= 1'b0;
         hlt_seen    <= 1'b0;
      end else begin
         state       <= state_nxt;
         phase       <= phase_nxt;
         executing   <= (phase_nxt != 3'd0);
         halted      <= (state_nxt == ST_HALT);
         brk_hit     <= brk_nxt;
         instr_count <= cnt_nxt;
         step_lat    <= step_nxt;
         stop_req    <= stop_nxt;
         hlt_seen    <= hlt_nxt;
      end
   end

endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer
//   Directed bench for phase_sequencer. Counter width is reduced to 3 bits
//   so saturation (7) is reachable in a short run.
module tb_phase_sequencer;

   localparam int unsigned CNT_W = 3;
   localparam int unsigned PC_W  = 16;
   localparam int CNT_MAX = 7;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             exec = 1'b1;
   logic             step_mode = 1'b0;
   logic             hlt = 1'b0;
   logic             mem_wait = 1'b0;
   logic             bp_en = 1'b0;
   logic [PC_W-1:0]  bp_addr = '0;
   logic [PC_W-1:0]  pc = '0;
   logic [2:0]       phase;
   logic             executing;
   logic             halted;
   logic             brk_hit;
   logic [CNT_W-1:0] instr_count;

   int n_checks = 0;
   int n_fail   = 0;

   phase_sequencer #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
      .clk         (clk),
      .rst         (rst),
      .exec        (exec),
      .step_mode   (step_mode),
      .hlt         (hlt),
      .mem_wait    (mem_wait),
      .bp_en       (bp_en),
      .bp_addr     (bp_addr),
      .pc          (pc),
      .phase       (phase),
      .executing   (executing),
      .halted      (halted),
      .brk_hit     (brk_hit),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_ph(input string tag, input int exp_ph);
      check({tag, ".phase"}, 32'(phase), 32'(exp_ph));
      check({tag, ".executing"}, 32'(executing), 32'(exp_ph != 0));
   endtask

   task automatic chk_all(input string tag, input int exp_ph, input int exp_hl,
                          input int exp_bk, input int exp_cnt);
      chk_ph(tag, exp_ph);
      check({tag, ".halted"}, 32'(halted), 32'(exp_hl));
      check({tag, ".brk_hit"}, 32'(brk_hit), 32'(exp_bk));
      check({tag, ".count"}, 32'(instr_count), 32'(exp_cnt));
   endtask

   task automatic do_reset();
      rst       = 1'b0;
      exec      = 1'b1;
      step_mode = 1'b0;
      hlt       = 1'b0;
      mem_wait  = 1'b0;
      bp_en     = 1'b0;
      bp_addr   = '0;
      pc        = '0;
      #3;
      chk_all("reset", 0, 0, 0, 0);
      rst = 1'b1;
   endtask

   // One-cycle low pulse on exec; the press is pending on return and is
   // consumed by the next clock edge.
   task automatic do_press();
      exec = 1'b0;
      tick();
      exec = 1'b1;
      tick();
   endtask

   // From phase 1: phases 2..5 with no stalls
   task automatic body(input string tag);
      for (int p = 2; p <= 5; p++) begin
         tick();
         chk_ph(tag, p);
      end
   endtask

   initial begin
      // ---- reset, idle with exec released, then exec held low ----
      do_reset();
      for (int i = 0; i < 10; i++) begin
         tick();
         chk_all("idle", 0, 0, 0, 0);
      end
      exec = 1'b0;
      tick();
      tick();
      chk_ph("lat_n1", 0);
      tick();
      chk_ph("lat_n2", 1);
      for (int i = 1; i <= 10; i++) begin
         tick();
         chk_ph("free", (i % 5) + 1);
         check("free.count", 32'(instr_count), 32'(i / 5));
      end

      // ---- memory stall in phase 4 (3 cycles) ----
      tick(); chk_ph("stall", 2);
      tick(); chk_ph("stall", 3);
      tick(); chk_ph("stall", 4);
      mem_wait = 1'b1;
      tick(); chk_ph("stall4a", 4);
      tick(); chk_ph("stall4b", 4);
      tick(); chk_ph("stall4c", 4);
      mem_wait = 1'b0;
      tick(); chk_all("stall5", 5, 0, 0, 2);
      tick(); chk_all("stall_exit", 1, 0, 0, 3);

      // ---- mem_wait ignored in 2, 3, 5; honoured in 1 ----
      tick(); chk_ph("mw", 2);
      mem_wait = 1'b1;
      tick(); chk_ph("mw_ign2", 3);
      tick(); chk_ph("mw_ign3", 4);
      mem_wait = 1'b0;
      tick(); chk_ph("mw", 5);
      mem_wait = 1'b1;
      tick(); chk_all("mw_ign5", 1, 0, 0, 4);
      tick(); chk_ph("mw_hold1", 1);
      mem_wait = 1'b0;
      tick(); chk_ph("mw_rel1", 2);

      // ---- single step: 3 presses, step_lat not resampled ----
      do_reset();
      step_mode = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         do_press();
         tick();
         chk_ph("step_start", 1);
         if (k == 3)
            step_mode = 1'b0;
         body("step");
         tick();
         chk_all("step_end", 0, 0, 0, k);
         tick();
         chk_ph("step_idle", 0);
      end

      // ---- breakpoint at pc 4 ----
      do_reset();
      bp_en   = 1'b1;
      bp_addr = 16'h0004;
      pc      = 16'h0001;
      do_press();
      tick();
      chk_ph("bp_start", 1);
      for (int k = 1; k <= 4; k++) begin
         pc = PC_W'(k);
         body("bp");
         tick();
         if (k < 4)
            chk_all("bp_cont", 1, 0, 0, k);
         else
            chk_all("bp_hit", 0, 0, 1, 4);
      end
      tick();
      chk_all("bp_after", 0, 0, 0, 4);

      // ---- halt in phase 3, then two presses ----
      pc = 16'h0005;
      do_press();
      tick(); chk_ph("hl", 1);
      tick(); chk_ph("hl", 2);
      tick(); chk_ph("hl", 3);
      hlt = 1'b1;
      tick(); chk_ph("hl", 4);
      hlt = 1'b0;
      tick(); chk_ph("hl", 5);
      tick(); chk_all("hl_stop", 0, 1, 0, 5);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all("hl_stay", 0, 1, 0, 5);
      end
      do_press();
      tick(); chk_all("hl_clear", 0, 0, 0, 5);
      tick(); chk_ph("hl_noadv", 0);
      do_press();
      tick(); chk_ph("hl_restart", 1);

      // ---- press during phase 2/3 sets stop_req ----
      do_press();
      chk_ph("sr", 3);
      tick(); chk_ph("sr", 4);
      tick(); chk_ph("sr", 5);
      tick(); chk_all("sr_stop", 0, 0, 0, 6);
      tick(); chk_ph("sr_idle", 0);

      // ---- halt and breakpoint together: halt wins ----
      do_reset();
      bp_en   = 1'b1;
      bp_addr = 16'h0007;
      pc      = 16'h0007;
      do_press();
      tick(); chk_ph("both", 1);
      tick(); chk_ph("both", 2);
      tick(); chk_ph("both", 3);
      tick(); chk_ph("both", 4);
      hlt = 1'b1;
      tick(); chk_ph("both", 5);
      tick(); chk_all("both_end", 0, 1, 0, 1);
      hlt = 1'b0;
      tick(); chk_all("both_after", 0, 1, 0, 1);

      // ---- press landing in phase 5 of free run ----
      do_reset();
      do_press();
      tick(); chk_ph("p5", 1);
      tick(); chk_ph("p5", 2);
      tick(); chk_ph("p5", 3);
      do_press();
      chk_ph("p5_in5", 5);
      tick(); chk_all("p5_stop", 0, 0, 0, 1);
      tick(); chk_ph("p5_idle", 0);

      // ---- asynchronous reset during phase 3 ----
      do_reset();
      do_press();
      tick(); chk_ph("ar", 1);
      tick(); chk_ph("ar", 2);
      tick(); chk_ph("ar", 3);
      #2;
      rst = 1'b0;
      #1;
      chk_all("ar_async", 0, 0, 0, 0);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_all("ar_idle", 0, 0, 0, 0);
      end

      // ---- counter saturation ----
      do_reset();
      exec = 1'b0;
      tick();
      tick();
      tick();
      chk_ph("sat_start", 1);
      for (int i = 1; i <= 45; i++) begin
         tick();
         if ((i % 5) == 0) begin
            chk_ph("sat", 1);
            check("sat.count", 32'(instr_count),
                  32'(((i / 5) > CNT_MAX) ? CNT_MAX : (i / 5)));
         end
      end
      exec = 1'b1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
